// File: rtl/sargantana_icache_pkg.sv
// Shared types and constants for the Sargantana instruction cache.
package sargantana_icache_pkg;

   typedef enum logic [2:0] {
      REFILL_IDLE,
      REFILL_REQ,
      REFILL_COLLECT,
      REFILL_WRITE,
      REFILL_DRAIN
   } refill_state_t;

   localparam int ICACHE_BEAT_WIDTH = 64;

endpackage

// File: rtl/sargantana_icache_refill.sv
// Line-fill engine: requests a missing line from L2, assembles the beats into a full line,
// then writes it into the selected way RAM in a single cycle.
module sargantana_icache_refill
   import sargantana_icache_pkg::*;
#(
   parameter int SET_WIDHT  = 256,
   parameter int ADDR_WIDHT = 6,
   parameter int BEAT_WIDTH = ICACHE_BEAT_WIDTH,
   parameter int WAY_NUM    = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       miss_valid_i,
   output logic                       miss_ready_o,
   input  logic [ADDR_WIDHT-1:0]      miss_idx_i,
   input  logic [$clog2(WAY_NUM)-1:0] miss_way_i,
   input  logic                       kill_i,
   output logic                       l2_req_valid_o,
   input  logic                       l2_req_ready_i,
   output logic [ADDR_WIDHT-1:0]      l2_req_idx_o,
   input  logic                       beat_valid_i,
   input  logic [BEAT_WIDTH-1:0]      beat_data_i,
   input  logic                       beat_last_i,
   input  logic                       beat_err_i,
   output logic [WAY_NUM-1:0]         way_req_o,
   output logic                       way_we_o,
   output logic [ADDR_WIDHT-1:0]      way_addr_o,
   output logic [SET_WIDHT-1:0]       way_data_o,
   output logic                       fill_done_o,
   output logic                       fill_err_o,
   output logic                       busy_o
);

   localparam int NBEATS = SET_WIDHT / BEAT_WIDTH;
   localparam int CNT_W  = $clog2(NBEATS) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBEATS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBEATS - 1);

   refill_state_t                state;
   logic [CNT_W-1:0]             cnt;
   logic [SET_WIDHT-1:0]         line_buf;
   logic [ADDR_WIDHT-1:0]        idx_q;
   logic [$clog2(WAY_NUM)-1:0]   way_q;
   logic                         err_q;
   logic                         fault;

   // Any error seen so far, an error on this beat, a premature last, or an overflow beat.
   assign fault = err_q | beat_err_i | (beat_last_i && (cnt != CNT_LAST)) | (cnt == CNT_FULL);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= REFILL_IDLE;
         cnt            <= '0;
         line_buf       <= '0;
         idx_q          <= '0;
         way_q          <= '0;
         err_q          <= 1'b0;
         miss_ready_o   <= 1'b1;
         l2_req_valid_o <= 1'b0;
         way_req_o      <= '0;
         way_we_o       <= 1'b0;
         fill_done_o    <= 1'b0;
         fill_err_o     <= 1'b0;
      end else begin
         way_req_o   <= '0;
         way_we_o    <= 1'b0;
         fill_done_o <= 1'b0;
         fill_err_o  <= 1'b0;
         case (state)
            REFILL_IDLE: begin
               if (miss_valid_i) begin
                  idx_q          <= miss_idx_i;
                  way_q          <= miss_way_i;
                  cnt            <= '0;
                  err_q          <= 1'b0;
                  miss_ready_o   <= 1'b0;
                  l2_req_valid_o <= 1'b1;
                  state          <= REFILL_REQ;
               end
            end
            REFILL_REQ: begin
               if (l2_req_ready_i) begin
                  l2_req_valid_o <= 1'b0;
                  state          <= kill_i ? REFILL_DRAIN : REFILL_COLLECT;
               end else if (kill_i) begin
                  l2_req_valid_o <= 1'b0;
                  miss_ready_o   <= 1'b1;
                  state          <= REFILL_IDLE;
               end
            end
            REFILL_COLLECT: begin
               if (beat_valid_i) begin
                  for (int b = 0; b < NBEATS; b++)
                     if (cnt == CNT_W'(b)) line_buf[b*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data_i;
                  if (cnt != CNT_FULL) cnt <= cnt + 1'b1;
                  if (kill_i) begin
                     if (beat_last_i) begin
                        miss_ready_o <= 1'b1;
                        state        <= REFILL_IDLE;
                     end else begin
                        state <= REFILL_DRAIN;
                     end
                  end else if (beat_last_i) begin
                     if (fault) begin
                        fill_err_o   <= 1'b1;
                        miss_ready_o <= 1'b1;
                        state        <= REFILL_IDLE;
                     end else begin
                        way_req_o   <= WAY_NUM'(1) << way_q;
                        way_we_o    <= 1'b1;
                        fill_done_o <= 1'b1;
                        state       <= REFILL_WRITE;
                     end
                  end else if (fault) begin
                     err_q <= 1'b1;
                  end
               end else if (kill_i) begin
                  state <= REFILL_DRAIN;
               end
            end
            REFILL_WRITE: begin
               miss_ready_o <= 1'b1;
               state        <= REFILL_IDLE;
            end
            REFILL_DRAIN: begin
               if (beat_valid_i && beat_last_i) begin
                  miss_ready_o <= 1'b1;
                  state        <= REFILL_IDLE;
               end
            end
            default: begin
               miss_ready_o   <= 1'b1;
               l2_req_valid_o <= 1'b0;
               state          <= REFILL_IDLE;
            end
         endcase
      end
   end

   // Wide payloads are gated by their registered strobes so they read zero outside their states.
   assign l2_req_idx_o = l2_req_valid_o ? idx_q : '0;
   assign way_addr_o   = way_we_o ? idx_q : '0;
   assign way_data_o   = way_we_o ? line_buf : '0;
   assign busy_o       = (state != REFILL_IDLE);

endmodule

// File: tb/tb_sargantana_icache_refill.sv
// Directed self-checking bench for the icache line-fill engine.
module tb_sargantana_icache_refill;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         miss_valid_i = 1'b0;
   logic         miss_ready_o;
   logic [5:0]   miss_idx_i = '0;
   logic [1:0]   miss_way_i = '0;
   logic         kill_i = 1'b0;
   logic         l2_req_valid_o;
   logic         l2_req_ready_i = 1'b0;
   logic [5:0]   l2_req_idx_o;
   logic         beat_valid_i = 1'b0;
   logic [63:0]  beat_data_i = '0;
   logic         beat_last_i = 1'b0;
   logic         beat_err_i = 1'b0;
   logic [3:0]   way_req_o;
   logic         way_we_o;
   logic [5:0]   way_addr_o;
   logic [255:0] way_data_o;
   logic         fill_done_o;
   logic         fill_err_o;
   logic         busy_o;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [63:0] B0 = 64'h1111_1111_1111_1111;
   localparam logic [63:0] B1 = 64'h2222_2222_2222_2222;
   localparam logic [63:0] B2 = 64'h3333_3333_3333_3333;
   localparam logic [63:0] B3 = 64'h4444_4444_4444_4444;
   localparam logic [63:0] C0 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] C1 = 64'hFEDC_BA98_7654_3210;
   localparam logic [63:0] C2 = 64'hDEAD_BEEF_0000_0001;
   localparam logic [63:0] C3 = 64'hCAFE_F00D_8000_0000;

   sargantana_icache_refill dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
      .miss_idx_i(miss_idx_i), .miss_way_i(miss_way_i), .kill_i(kill_i),
      .l2_req_valid_o(l2_req_valid_o), .l2_req_ready_i(l2_req_ready_i), .l2_req_idx_o(l2_req_idx_o),
      .beat_valid_i(beat_valid_i), .beat_data_i(beat_data_i),
      .beat_last_i(beat_last_i), .beat_err_i(beat_err_i),
      .way_req_o(way_req_o), .way_we_o(way_we_o), .way_addr_o(way_addr_o), .way_data_o(way_data_o),
      .fill_done_o(fill_done_o), .fill_err_o(fill_err_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_miss(input logic [5:0] idx, input logic [1:0] way);
      miss_valid_i = 1'b1; miss_idx_i = idx; miss_way_i = way;
      tick();
      miss_valid_i = 1'b0;
   endtask

   task automatic handshake();
      l2_req_ready_i = 1'b1;
      tick();
      l2_req_ready_i = 1'b0;
   endtask

   task automatic beat(input logic [63:0] d, input logic last, input logic err);
      beat_valid_i = 1'b1; beat_data_i = d; beat_last_i = last; beat_err_i = err;
      tick();
      beat_valid_i = 1'b0; beat_last_i = 1'b0; beat_err_i = 1'b0; beat_data_i = '0;
   endtask

   task automatic chk_idle_quiet(input string tag);
      chk({tag, "_ready"}, 256'(miss_ready_o), 256'(1'b1));
      chk({tag, "_busy"}, 256'(busy_o), 256'(1'b0));
      chk({tag, "_wreq"}, 256'(way_req_o), 256'(4'b0000));
      chk({tag, "_done"}, 256'(fill_done_o), 256'(1'b0));
   endtask

   initial begin
      // Reset
      tick(); tick();
      chk_idle_quiet("rst");
      chk("rst_l2v", 256'(l2_req_valid_o), 256'(1'b0));
      chk("rst_err", 256'(fill_err_o), 256'(1'b0));
      chk("rst_data", way_data_o, 256'(0));
      rst_i = 1'b0;
      tick();

      // Normal fill, idx 0x2A way 2
      start_miss(6'h2A, 2'd2);
      chk("nf_l2v", 256'(l2_req_valid_o), 256'(1'b1));
      chk("nf_l2idx", 256'(l2_req_idx_o), 256'(6'h2A));
      chk("nf_ready", 256'(miss_ready_o), 256'(1'b0));
      chk("nf_busy", 256'(busy_o), 256'(1'b1));
      handshake();
      chk("nf_l2v_off", 256'(l2_req_valid_o), 256'(1'b0));
      beat(B0, 1'b0, 1'b0);
      beat(B1, 1'b0, 1'b0);
      beat(B2, 1'b0, 1'b0);
      chk("nf_nowrite_early", 256'(way_we_o), 256'(1'b0));
      beat(B3, 1'b1, 1'b0);
      chk("nf_wreq", 256'(way_req_o), 256'(4'b0100));
      chk("nf_we", 256'(way_we_o), 256'(1'b1));
      chk("nf_addr", 256'(way_addr_o), 256'(6'h2A));
      chk("nf_data", way_data_o, {B3, B2, B1, B0});
      chk("nf_done", 256'(fill_done_o), 256'(1'b1));
      tick();
      chk_idle_quiet("nf_after");
      chk("nf_data_zero", way_data_o, 256'(0));

      // L2 stall: ready low 5 cycles with spurious beats that must be ignored
      start_miss(6'h05, 2'd1);
      for (int i = 0; i < 5; i++) begin
         beat_valid_i = 1'b1; beat_data_i = 64'hBAD0_BAD0_BAD0_BAD0;
         tick();
         chk($sformatf("stall_l2v_%0d", i), 256'(l2_req_valid_o), 256'(1'b1));
         chk($sformatf("stall_idx_%0d", i), 256'(l2_req_idx_o), 256'(6'h05));
      end
      beat_valid_i = 1'b0; beat_data_i = '0;
      handshake();
      beat(C0, 1'b0, 1'b0);
      beat(C1, 1'b0, 1'b0);
      beat(C2, 1'b0, 1'b0);
      beat(C3, 1'b1, 1'b0);
      chk("stall_wreq", 256'(way_req_o), 256'(4'b0010));
      chk("stall_addr", 256'(way_addr_o), 256'(6'h05));
      chk("stall_data", way_data_o, {C3, C2, C1, C0});
      tick();

      // Bus error on beat 1
      start_miss(6'h10, 2'd0);
      handshake();
      beat(B0, 1'b0, 1'b0);
      beat(B1, 1'b0, 1'b1);
      beat(B2, 1'b0, 1'b0);
      chk("err_noerr_yet", 256'(fill_err_o), 256'(1'b0));
      beat(B3, 1'b1, 1'b0);
      chk("err_pulse", 256'(fill_err_o), 256'(1'b1));
      chk("err_nowrite", 256'(way_req_o), 256'(4'b0000));
      chk("err_nodone", 256'(fill_done_o), 256'(1'b0));
      chk("err_ready", 256'(miss_ready_o), 256'(1'b1));
      tick();
      chk("err_pulse_end", 256'(fill_err_o), 256'(1'b0));

      // Early last on second beat
      start_miss(6'h11, 2'd3);
      handshake();
      beat(B0, 1'b0, 1'b0);
      beat(B1, 1'b1, 1'b0);
      chk("early_err", 256'(fill_err_o), 256'(1'b1));
      chk("early_nowe", 256'(way_we_o), 256'(1'b0));
      tick();

      // Six-beat burst: extras dropped, error at the final beat
      start_miss(6'h12, 2'd3);
      handshake();
      beat(B0, 1'b0, 1'b0);
      beat(B1, 1'b0, 1'b0);
      beat(B2, 1'b0, 1'b0);
      beat(B3, 1'b0, 1'b0);
      beat(C0, 1'b0, 1'b0);
      chk("long_busy", 256'(busy_o), 256'(1'b1));
      chk("long_noerr_yet", 256'(fill_err_o), 256'(1'b0));
      beat(C1, 1'b1, 1'b0);
      chk("long_err", 256'(fill_err_o), 256'(1'b1));
      chk("long_nowe", 256'(way_we_o), 256'(1'b0));
      tick();

      // Kill in COLLECT after two beats
      start_miss(6'h13, 2'd1);
      handshake();
      beat(B0, 1'b0, 1'b0);
      beat(B1, 1'b0, 1'b0);
      kill_i = 1'b1;
      tick();
      kill_i = 1'b0;
      beat(B2, 1'b0, 1'b0);
      chk("kill_drain_ready", 256'(miss_ready_o), 256'(1'b0));
      beat(B3, 1'b1, 1'b0);
      chk_idle_quiet("kill_end");
      chk("kill_noerr", 256'(fill_err_o), 256'(1'b0));
      tick();
      chk("kill_noerr2", 256'(fill_err_o), 256'(1'b0));

      // Kill in REQ before handshake withdraws the request
      start_miss(6'h14, 2'd0);
      kill_i = 1'b1;
      tick();
      kill_i = 1'b0;
      chk("kreq_l2v", 256'(l2_req_valid_o), 256'(1'b0));
      chk_idle_quiet("kreq");
      chk("kreq_noerr", 256'(fill_err_o), 256'(1'b0));

      // Back-to-back misses with miss_valid held high
      miss_valid_i = 1'b1; miss_idx_i = 6'h20; miss_way_i = 2'd0;
      tick();
      handshake();
      beat(B0, 1'b0, 1'b0);
      beat(B1, 1'b0, 1'b0);
      beat(B2, 1'b0, 1'b0);
      beat(B3, 1'b1, 1'b0);
      chk("b2b_done", 256'(fill_done_o), 256'(1'b1));
      chk("b2b_wreq", 256'(way_req_o), 256'(4'b0001));
      chk("b2b_ready_w", 256'(miss_ready_o), 256'(1'b0));
      tick();
      chk("b2b_ready_idle", 256'(miss_ready_o), 256'(1'b1));
      chk("b2b_l2v_idle", 256'(l2_req_valid_o), 256'(1'b0));
      tick();
      miss_valid_i = 1'b0;
      chk("b2b_second_l2v", 256'(l2_req_valid_o), 256'(1'b1));
      chk("b2b_second_idx", 256'(l2_req_idx_o), 256'(6'h20));

      // Reset in the middle of COLLECT
      handshake();
      beat(B0, 1'b0, 1'b0);
      beat(B1, 1'b0, 1'b0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk_idle_quiet("mrst");
      chk("mrst_l2v", 256'(l2_req_valid_o), 256'(1'b0));
      beat(B2, 1'b0, 1'b0);
      beat(B3, 1'b1, 1'b0);
      chk_idle_quiet("mrst_after");
      chk("mrst_noerr", 256'(fill_err_o), 256'(1'b0));
      chk("mrst_nowe", 256'(way_we_o), 256'(1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
